alu_instr_sequencer: RTL and testbench



---
 rtl/alu_pkg.sv | 14 +
 rtl/alu_instr_sequencer_if.sv | 28 ++
 rtl/alu_prog_buffer.sv | 28 ++
 rtl/alu_instr_sequencer.sv | 106 ++++++++++
 tb/tb_alu_instr_sequencer.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU instruction sequencer: instruction width, FSM states and the
// halt opcode used when ALU_SEQ_HALT_EN is defined.
package alu_pkg;

    localparam int unsigned IW = 8;
    localparam logic [IW-1:0] HALT_OPCODE = 8'hFF;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StIssue = 2'd1,
        StDone  = 2'd2
    } seq_state_e;

endpackage

// File: rtl/alu_instr_sequencer_if.sv
// Program-load, control and ALU-issue signals of the instruction sequencer.
// master drives program/control inputs; slave is the sequencer itself.
interface alu_instr_sequencer_if #(
    parameter int unsigned AW = 4,
    parameter int unsigned IW = 8
) ();
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [IW-1:0] wr_data;
    logic [AW:0]   prog_len;
    logic          start;
    logic          alu_ready;
    logic [IW-1:0] instrucciones;
    logic          active;
    logic          busy;
    logic          done;
    logic [AW:0]   pc;

    modport master (
        output wr_en, wr_addr, wr_data, prog_len, start, alu_ready,
        input  instrucciones, active, busy, done, pc
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, prog_len, start, alu_ready,
        output instrucciones, active, busy, done, pc
    );
endinterface

// File: rtl/alu_prog_buffer.sv
// DEPTH x IW program store: synchronous write, asynchronous read, cleared by synchronous reset.
module alu_prog_buffer #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned IW    = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);
    logic [IW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];
endmodule

// File: rtl/alu_instr_sequencer.sv
// Issues a loaded program to the ALU one word per ready cycle; reports busy/done.
// Optional: define ALU_SEQ_HALT_EN to treat HALT_OPCODE in the buffer as an end-of-program marker.
module alu_instr_sequencer
    import alu_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned IW    = alu_pkg::IW
) (
    input logic                  clk,
    input logic                  reset,
    alu_instr_sequencer_if.slave bus
);
    localparam logic [AW:0] MaxLen = (AW + 1)'(DEPTH);

    seq_state_e    state_q;
    logic [AW:0]   pc_q;
    logic [AW:0]   len_q;
    logic [IW-1:0] instr_q;
    logic          active_q;
    logic          done_q;
    logic          busy_q;
    logic [IW-1:0] rd_data;
    logic          buf_we;

    // Program may only change while nothing is being issued.
    assign buf_we = bus.wr_en && (state_q != StIssue);

    alu_prog_buffer #(
        .DEPTH(DEPTH),
        .AW   (AW),
        .IW   (IW)
    ) u_buf (
        .clk  (clk),
        .reset(reset),
        .we   (buf_we),
        .waddr(bus.wr_addr),
        .wdata(bus.wr_data),
        .raddr(pc_q[AW-1:0]),
        .rdata(rd_data)
    );

    function automatic logic [AW:0] clamp_len(input logic [AW:0] len);
        return (len > MaxLen) ? MaxLen : len;
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            pc_q     <= '0;
            len_q    <= '0;
            instr_q  <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            active_q <= 1'b0;
            done_q   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        len_q <= clamp_len(bus.prog_len);
                        pc_q  <= '0;
                        if (bus.prog_len == '0) begin
                            state_q <= StDone;
                        end else begin
                            state_q <= StIssue;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                StIssue: begin
`ifdef ALU_SEQ_HALT_EN
                    if (rd_data == HALT_OPCODE) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                    end else
`endif
                    if (bus.alu_ready) begin
                        instr_q  <= rd_data;
                        active_q <= 1'b1;
                        pc_q     <= pc_q + 1'b1;
                        if (pc_q == len_q - 1'b1) begin
                            state_q <= StDone;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                StDone: begin
                    done_q  <= 1'b1;
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.instrucciones = instr_q;
    assign bus.active        = active_q;
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;
    assign bus.pc            = pc_q;
endmodule

// File: tb/tb_alu_instr_sequencer.sv
// Directed bench for alu_instr_sequencer; expectations follow ALU_SEQ_HALT_EN when defined.
module tb_alu_instr_sequencer;
    localparam int unsigned AW = 4;
    localparam int unsigned IW = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    alu_instr_sequencer_if #(.AW(AW), .IW(IW)) bus ();

    alu_instr_sequencer #(
        .DEPTH(16),
        .AW   (AW),
        .IW   (IW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] addr, input logic [IW-1:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        step();
        bus.wr_en = 1'b0;
    endtask

    // Sample active/instrucciones/pc right after an edge.
    task automatic chk_issue(input string tag, input logic act, input logic [IW-1:0] ins,
                             input logic [AW:0] pc);
        chk({tag, "_active"}, 32'(bus.active), 32'(act));
        chk({tag, "_instr"}, 32'(bus.instrucciones), 32'(ins));
        chk({tag, "_pc"}, 32'(bus.pc), 32'(pc));
    endtask

    initial begin
        reset         = 1'b1;
        bus.wr_en     = 1'b0;
        bus.wr_addr   = '0;
        bus.wr_data   = '0;
        bus.prog_len  = '0;
        bus.start     = 1'b0;
        bus.alu_ready = 1'b0;
        step();
        step();
        reset = 1'b0;
        chk("rst_active", 32'(bus.active), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_pc", 32'(bus.pc), 32'd0);
        chk("rst_instr", 32'(bus.instrucciones), 32'd0);

        // Straight run, ready always high.
        wr(4'd0, 8'hC3);
        wr(4'd1, 8'hD3);
        wr(4'd2, 8'h08);
        bus.prog_len  = 5'd3;
        bus.start     = 1'b1;
        bus.alu_ready = 1'b1;
        step();
        bus.start = 1'b0;
        chk("t1_busy", 32'(bus.busy), 32'd1);
        chk("t1_idle_active", 32'(bus.active), 32'd0);
        step(); chk_issue("t1_i0", 1'b1, 8'hC3, 5'd1);
        step(); chk_issue("t1_i1", 1'b1, 8'hD3, 5'd2);
        step(); chk_issue("t1_i2", 1'b1, 8'h08, 5'd3);
        chk("t1_busy_end", 32'(bus.busy), 32'd0);
        chk("t1_done_early", 32'(bus.done), 32'd0);
        step();
        chk("t1_done", 32'(bus.done), 32'd1);
        chk_issue("t1_after", 1'b0, 8'h08, 5'd3);
        step();
        chk("t1_done_pulse", 32'(bus.done), 32'd0);

        // Throttled by alu_ready 1,0,1,0,1.
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step(); chk_issue("t2_r1", 1'b1, 8'hC3, 5'd1);
        bus.alu_ready = 1'b0;
        step(); chk_issue("t2_r0", 1'b0, 8'hC3, 5'd1);
        bus.alu_ready = 1'b1;
        step(); chk_issue("t2_r1b", 1'b1, 8'hD3, 5'd2);
        bus.alu_ready = 1'b0;
        step(); chk_issue("t2_r0b", 1'b0, 8'hD3, 5'd2);
        bus.alu_ready = 1'b1;
        step(); chk_issue("t2_r1c", 1'b1, 8'h08, 5'd3);
        step();
        chk("t2_done", 32'(bus.done), 32'd1);

        // Empty program.
        bus.prog_len = 5'd0;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        chk("t3_busy", 32'(bus.busy), 32'd0);
        chk("t3_done_early", 32'(bus.done), 32'd0);
        step();
        chk("t3_done", 32'(bus.done), 32'd1);
        chk("t3_active", 32'(bus.active), 32'd0);
        step();
        chk("t3_done_clr", 32'(bus.done), 32'd0);

        // Reset after first issue clears everything including the program.
        bus.prog_len = 5'd3;
        bus.start    = 1'b1;
        step();
        bus.start = 1'b0;
        step(); chk_issue("t4_i0", 1'b1, 8'hC3, 5'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_issue("t4_rst", 1'b0, 8'h00, 5'd0);
        chk("t4_rst_busy", 32'(bus.busy), 32'd0);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step(); chk_issue("t4_clr0", 1'b1, 8'h00, 5'd1);
        step(); chk_issue("t4_clr1", 1'b1, 8'h00, 5'd2);
        step(); step();
        chk("t4_done", 32'(bus.done), 32'd1);

        // Writes ignored while busy, accepted when idle.
        wr(4'd0, 8'hC3);
        wr(4'd1, 8'hD3);
        wr(4'd2, 8'h08);
        bus.alu_ready = 1'b0;
        bus.start     = 1'b1;
        step();
        bus.start = 1'b0;
        wr(4'd1, 8'h55);
        bus.alu_ready = 1'b1;
        step(); chk_issue("t5_b0", 1'b1, 8'hC3, 5'd1);
        step(); chk_issue("t5_b1", 1'b1, 8'hD3, 5'd2);
        step(); step();
        wr(4'd1, 8'h55);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step(); chk_issue("t5_i0", 1'b1, 8'hC3, 5'd1);
        step(); chk_issue("t5_i1", 1'b1, 8'h55, 5'd2);
        step(); chk_issue("t5_i2", 1'b1, 8'h08, 5'd3);
        step();

        // Halt marker behaviour.
        wr(4'd1, 8'hFF);
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        step(); chk_issue("t6_i0", 1'b1, 8'hC3, 5'd1);
`ifdef ALU_SEQ_HALT_EN
        step(); chk_issue("t6_halt", 1'b0, 8'hC3, 5'd1);
        chk("t6_busy", 32'(bus.busy), 32'd0);
        step();
        chk("t6_done", 32'(bus.done), 32'd1);
        chk("t6_active", 32'(bus.active), 32'd0);
`else
        step(); chk_issue("t6_i1", 1'b1, 8'hFF, 5'd2);
        step(); chk_issue("t6_i2", 1'b1, 8'h08, 5'd3);
        step();
        chk("t6_done", 32'(bus.done), 32'd1);
`endif
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
